// File: rtl/pwm_axil_cfg_seq.sv
// AXI4-Lite master that loads the PwmIp_Demo register bank from a latched configuration vector.
// It then reads every register back and reports done, plus error and err_index on the first mismatch.
module pwm_axil_cfg_seq #(
  parameter int NUM_REGS   = 4,
  parameter int ADDR_WIDTH = 4,
  parameter int BASE_ADDR  = 0
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic                    start,
  input  logic [32*NUM_REGS-1:0]  cfg_data,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic [3:0]              err_index,
  output logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]              M_AXI_AWPROT,
  output logic                    M_AXI_AWVALID,
  input  logic                    M_AXI_AWREADY,
  output logic [31:0]             M_AXI_WDATA,
  output logic [3:0]              M_AXI_WSTRB,
  output logic                    M_AXI_WVALID,
  input  logic                    M_AXI_WREADY,
  input  logic [1:0]              M_AXI_BRESP,
  input  logic                    M_AXI_BVALID,
  output logic                    M_AXI_BREADY,
  output logic [ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]              M_AXI_ARPROT,
  output logic                    M_AXI_ARVALID,
  input  logic                    M_AXI_ARREADY,
  input  logic [31:0]             M_AXI_RDATA,
  input  logic [1:0]              M_AXI_RRESP,
  input  logic                    M_AXI_RVALID,
  output logic                    M_AXI_RREADY
);

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, FINISH} state_t;

  localparam int                    PAD_W    = 32 * 16;
  localparam logic [3:0]            LAST_IDX = 4'(NUM_REGS - 1);
  localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);

  state_t                r_state, w_nextState;
  logic [3:0]            r_idx, w_nextIdx;
  logic [31:0]           r_shadow [16];
  logic [PAD_W-1:0]      w_cfgPad;
  logic                  r_awDone, r_wDone, w_awDoneNext, w_wDoneNext;
  logic                  w_awHs, w_wHs, w_fail;
  logic [ADDR_WIDTH-1:0] r_awaddr, r_araddr, w_nextAddr;
  logic [31:0]           r_wdata, w_nextWdata;
  logic                  r_error;
  logic [3:0]            r_errIndex;

  assign w_cfgPad    = PAD_W'(cfg_data);
  assign w_nextAddr  = BASE + ADDR_WIDTH'({w_nextIdx, 2'b00});
  assign w_nextWdata = (r_state == IDLE) ? w_cfgPad[31:0] : r_shadow[w_nextIdx];

  // Valids come only from registered state, never from a ready input.
  assign M_AXI_AWVALID = (r_state == WR_REQ) && !r_awDone;
  assign M_AXI_WVALID  = (r_state == WR_REQ) && !r_wDone;
  assign M_AXI_BREADY  = (r_state == WR_RESP);
  assign M_AXI_ARVALID = (r_state == RD_REQ);
  assign M_AXI_RREADY  = (r_state == RD_RESP);
  assign M_AXI_AWADDR  = r_awaddr;
  assign M_AXI_ARADDR  = r_araddr;
  assign M_AXI_WDATA   = r_wdata;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_WSTRB   = 4'hF;
  assign busy          = (r_state != IDLE) && (r_state != FINISH);
  assign done          = (r_state == FINISH);
  assign error         = r_error;
  assign err_index     = r_errIndex;

  always_ff @(posedge ACLK) begin
    if (ARESET) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState  = r_state;
    w_nextIdx    = r_idx;
    w_awDoneNext = r_awDone;
    w_wDoneNext  = r_wDone;
    w_awHs       = 1'b0;
    w_wHs        = 1'b0;
    w_fail       = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_nextState = WR_REQ;
          w_nextIdx   = 4'd0;
        end
      end
      WR_REQ: begin
        // AW and W may complete in either order; leave only once both have.
        w_awHs       = M_AXI_AWVALID && M_AXI_AWREADY;
        w_wHs        = M_AXI_WVALID && M_AXI_WREADY;
        w_awDoneNext = r_awDone || w_awHs;
        w_wDoneNext  = r_wDone || w_wHs;
        if (w_awDoneNext && w_wDoneNext) begin
          w_nextState  = WR_RESP;
          w_awDoneNext = 1'b0;
          w_wDoneNext  = 1'b0;
        end
      end
      WR_RESP: begin
        if (M_AXI_BVALID) begin
          if (M_AXI_BRESP != 2'b00) begin
            w_fail      = 1'b1;
            w_nextState = FINISH;
          end else if (r_idx == LAST_IDX) begin
            w_nextIdx   = 4'd0;
            w_nextState = RD_REQ;
          end else begin
            w_nextIdx   = r_idx + 4'd1;
            w_nextState = WR_REQ;
          end
        end
      end
      RD_REQ: begin
        if (M_AXI_ARREADY) w_nextState = RD_RESP;
      end
      RD_RESP: begin
        if (M_AXI_RVALID) begin
          if ((M_AXI_RRESP != 2'b00) || (M_AXI_RDATA != r_shadow[r_idx])) begin
            w_fail      = 1'b1;
            w_nextState = FINISH;
          end else if (r_idx == LAST_IDX) begin
            w_nextState = FINISH;
          end else begin
            w_nextIdx   = r_idx + 4'd1;
            w_nextState = RD_REQ;
          end
        end
      end
      FINISH:  w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Addresses and write data are loaded on entry to a request state so they stay stable while valid.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_idx      <= 4'd0;
      r_awDone   <= 1'b0;
      r_wDone    <= 1'b0;
      r_awaddr   <= '0;
      r_araddr   <= '0;
      r_wdata    <= 32'd0;
      r_error    <= 1'b0;
      r_errIndex <= 4'd0;
    end else begin
      r_idx    <= w_nextIdx;
      r_awDone <= w_awDoneNext;
      r_wDone  <= w_wDoneNext;
      if ((w_nextState == WR_REQ) && (r_state != WR_REQ)) begin
        r_awaddr <= w_nextAddr;
        r_wdata  <= w_nextWdata;
      end
      if ((w_nextState == RD_REQ) && (r_state != RD_REQ)) r_araddr <= w_nextAddr;
      if ((r_state == IDLE) && start) r_error <= 1'b0;
      if (w_fail) begin
        r_error    <= 1'b1;
        r_errIndex <= r_idx;
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESET && (r_state == IDLE) && start) begin
      for (int i = 0; i < 16; i++) r_shadow[i] <= w_cfgPad[32*i +: 32];
    end
  end

endmodule

// File: tb/tb_pwm_axil_cfg_seq.sv
// Randomized bench for pwm_axil_cfg_seq: a reactive AXI-Lite slave logs every transaction.
// The logs are compared against the write/read sequence expected from the configuration and the injected fault.
module tb_pwm_axil_cfg_seq;

  localparam int NREG = 4;

  logic              ACLK, ARESET, start;
  logic [32*NREG-1:0] cfg_data;
  logic              busy, done, error;
  logic [3:0]        err_index;
  logic [3:0]        M_AXI_AWADDR, M_AXI_ARADDR;
  logic [2:0]        M_AXI_AWPROT, M_AXI_ARPROT;
  logic              M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
  logic [31:0]       M_AXI_WDATA, M_AXI_RDATA;
  logic [3:0]        M_AXI_WSTRB;
  logic [1:0]        M_AXI_BRESP, M_AXI_RRESP;
  logic              M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
  logic              M_AXI_RVALID, M_AXI_RREADY;

  pwm_axil_cfg_seq #(.NUM_REGS(NREG), .ADDR_WIDTH(4), .BASE_ADDR(0)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .start(start), .cfg_data(cfg_data),
    .busy(busy), .done(done), .error(error), .err_index(err_index),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
    .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
    .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
  );

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] data;
  } wrEntry_t;

  int          vectorCount = 0;
  int          missCount   = 0;
  wrEntry_t    writeLog[$];
  logic [3:0]  readLog[$];
  logic [31:0] mem [NREG];
  int          faultMode, faultIdx;
  int          awMin, awMax, wMin, wMax, bMin, bMax, arMin, arMax, rMin, rMax;
  int          awWait, wWait, bWait, arWait, rWait;
  bit          haveAw, haveW, bPending, rPending, awHeld, wHeld, arHeld;
  logic [3:0]  wrAddr, rdAddr, awHeldAddr, arHeldAddr;
  logic [31:0] wrData, wHeldData;

  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic slaveReset();
    M_AXI_AWREADY = 1'b0;
    M_AXI_WREADY  = 1'b0;
    M_AXI_BVALID  = 1'b0;
    M_AXI_BRESP   = 2'b00;
    M_AXI_ARREADY = 1'b0;
    M_AXI_RVALID  = 1'b0;
    M_AXI_RRESP   = 2'b00;
    M_AXI_RDATA   = 32'd0;
    haveAw = 0; haveW = 0; bPending = 0; rPending = 0;
    awHeld = 0; wHeld = 0; arHeld = 0;
    awWait = $urandom_range(awMax, awMin);
    wWait  = $urandom_range(wMax, wMin);
    arWait = $urandom_range(arMax, arMin);
  endtask

  task automatic setDelays(input int lo, input int hi);
    awMin = lo; awMax = hi; wMin = lo; wMax = hi; bMin = lo; bMax = hi;
    arMin = lo; arMax = hi; rMin = lo; rMax = hi;
    awWait = $urandom_range(awMax, awMin);
    wWait  = $urandom_range(wMax, wMin);
    arWait = $urandom_range(arMax, arMin);
  endtask

  // Slave model: evaluated 1 time unit after each rising edge; a handshake decided here happens at the next edge.
  initial begin : slave
    for (int i = 0; i < NREG; i++) mem[i] = 32'd0;
    setDelays(0, 0);
    faultMode = 0;
    faultIdx  = 0;
    slaveReset();
    forever begin
      @(posedge ACLK);
      #1;
      if (ARESET) begin
        slaveReset();
      end else begin
        if (awHeld) begin
          checkOutput("awHold", 32'(M_AXI_AWVALID), 32'd1);
          checkOutput("awAddrHold", 32'(M_AXI_AWADDR), 32'(awHeldAddr));
        end
        if (wHeld) begin
          checkOutput("wHold", 32'(M_AXI_WVALID), 32'd1);
          checkOutput("wDataHold", M_AXI_WDATA, wHeldData);
        end
        if (arHeld) begin
          checkOutput("arHold", 32'(M_AXI_ARVALID), 32'd1);
          checkOutput("arAddrHold", 32'(M_AXI_ARADDR), 32'(arHeldAddr));
        end
        if (haveAw)   checkOutput("awSingle", 32'(M_AXI_AWVALID), 32'd0);
        if (haveW)    checkOutput("wSingle", 32'(M_AXI_WVALID), 32'd0);
        if (rPending) checkOutput("arSingle", 32'(M_AXI_ARVALID), 32'd0);

        M_AXI_BVALID = 1'b0;
        if (haveAw && haveW) begin
          if (!bPending) begin
            bPending = 1;
            bWait    = $urandom_range(bMax, bMin);
          end
          if (bWait == 0) begin
            M_AXI_BVALID = 1'b1;
            M_AXI_BRESP  = (faultMode == 1 && writeLog.size() == faultIdx) ? 2'b10 : 2'b00;
            if (M_AXI_BREADY) begin
              writeLog.push_back('{addr: wrAddr, data: wrData});
              if (M_AXI_BRESP == 2'b00) mem[wrAddr[3:2]] = wrData;
              haveAw = 0; haveW = 0; bPending = 0;
            end
          end else begin
            bWait--;
          end
        end

        awHeld = 0;
        M_AXI_AWREADY = 1'b0;
        if (M_AXI_AWVALID && !haveAw) begin
          if (awWait == 0) begin
            M_AXI_AWREADY = 1'b1;
            haveAw = 1;
            wrAddr = M_AXI_AWADDR;
            awWait = $urandom_range(awMax, awMin);
          end else begin
            awWait--;
            awHeld = 1;
            awHeldAddr = M_AXI_AWADDR;
          end
        end

        wHeld = 0;
        M_AXI_WREADY = 1'b0;
        if (M_AXI_WVALID && !haveW) begin
          if (wWait == 0) begin
            M_AXI_WREADY = 1'b1;
            haveW = 1;
            wrData = M_AXI_WDATA;
            wWait = $urandom_range(wMax, wMin);
          end else begin
            wWait--;
            wHeld = 1;
            wHeldData = M_AXI_WDATA;
          end
        end

        M_AXI_RVALID = 1'b0;
        if (rPending) begin
          if (rWait == 0) begin
            M_AXI_RVALID = 1'b1;
            M_AXI_RRESP  = 2'b00;
            M_AXI_RDATA  = (faultMode == 2 && readLog.size() == faultIdx) ? 32'hDEAD0000 : mem[rdAddr[3:2]];
            if (M_AXI_RREADY) begin
              readLog.push_back(rdAddr);
              rPending = 0;
            end
          end else begin
            rWait--;
          end
        end

        arHeld = 0;
        M_AXI_ARREADY = 1'b0;
        if (M_AXI_ARVALID && !rPending) begin
          if (arWait == 0) begin
            M_AXI_ARREADY = 1'b1;
            rPending = 1;
            rdAddr   = M_AXI_ARADDR;
            rWait    = $urandom_range(rMax, rMin);
            arWait   = $urandom_range(arMax, arMin);
          end else begin
            arWait--;
            arHeld = 1;
            arHeldAddr = M_AXI_ARADDR;
          end
        end
      end
    end
  end

  // One full sequence; expectations come from the configuration and the fault choice alone.
  task automatic applyStimulus(input logic [32*NREG-1:0] cfg, input int mode, input int fIdx,
                               input bit midStart, input bit checkLatency);
    int cyc;
    int nW, nR;
    bit expErr;
    faultMode = mode;
    faultIdx  = fIdx;
    writeLog.delete();
    readLog.delete();
    nW     = (mode == 1) ? fIdx + 1 : NREG;
    nR     = (mode == 1) ? 0 : (mode == 2) ? fIdx + 1 : NREG;
    expErr = (mode != 0);

    @(negedge ACLK);
    cfg_data = cfg;
    start    = 1'b1;
    @(negedge ACLK);
    start = 1'b0;
    cyc   = 1;
    checkOutput("busyUp", 32'(busy), 32'd1);
    checkOutput("errCleared", 32'(error), 32'd0);
    while (!done && cyc < 2000) begin
      if (midStart && cyc == 4) begin
        start    = 1'b1;
        cfg_data = ~cfg;
      end
      @(negedge ACLK);
      cyc++;
      start = 1'b0;
    end
    checkOutput("doneSeen", 32'(done), 32'd1);
    if (checkLatency) checkOutput("doneLatency", 32'(cyc), 32'd17);
    checkOutput("busyAtDone", 32'(busy), 32'd0);
    checkOutput("error", 32'(error), 32'(expErr));
    if (expErr) checkOutput("errIndex", 32'(err_index), 32'(fIdx));

    checkOutput("wrCount", 32'(writeLog.size()), 32'(nW));
    for (int i = 0; i < nW && i < writeLog.size(); i++) begin
      checkOutput("wrAddr", 32'(writeLog[i].addr), 32'(4 * i));
      checkOutput("wrData", writeLog[i].data, cfg[32*i +: 32]);
    end
    checkOutput("rdCount", 32'(readLog.size()), 32'(nR));
    for (int i = 0; i < nR && i < readLog.size(); i++)
      checkOutput("rdAddr", 32'(readLog[i]), 32'(4 * i));

    @(negedge ACLK);
    checkOutput("donePulse", 32'(done), 32'd0);
    repeat (3) @(negedge ACLK);
    checkOutput("idleAfter", 32'(busy), 32'd0);
    checkOutput("awQuiet", 32'(M_AXI_AWVALID), 32'd0);
    checkOutput("arQuiet", 32'(M_AXI_ARVALID), 32'd0);
  endtask

  task automatic applyResetMidRead(input logic [32*NREG-1:0] cfg);
    int cyc;
    faultMode = 0;
    setDelays(0, 0);
    arMin = 4; arMax = 4; arWait = 4;
    @(negedge ACLK);
    cfg_data = cfg;
    start    = 1'b1;
    @(negedge ACLK);
    start = 1'b0;
    cyc   = 1;
    while (!M_AXI_ARVALID && cyc < 300) begin
      @(negedge ACLK);
      cyc++;
    end
    checkOutput("arWaiting", 32'(M_AXI_ARVALID && !M_AXI_ARREADY), 32'd1);
    ARESET = 1'b1;
    @(negedge ACLK);
    checkOutput("rstArvalid", 32'(M_AXI_ARVALID), 32'd0);
    checkOutput("rstAwvalid", 32'(M_AXI_AWVALID), 32'd0);
    checkOutput("rstWvalid", 32'(M_AXI_WVALID), 32'd0);
    checkOutput("rstBusy", 32'(busy), 32'd0);
    checkOutput("rstNoDone", 32'(done), 32'd0);
    ARESET = 1'b0;
    @(negedge ACLK);
    checkOutput("rstNoDoneAfter", 32'(done), 32'd0);
    setDelays(0, 0);
  endtask

  initial begin : main
    logic [32*NREG-1:0] cfg;
    int mode, fIdx;
    ARESET   = 1'b1;
    start    = 1'b0;
    cfg_data = '0;
    repeat (3) @(negedge ACLK);
    checkOutput("rstAwvalid0", 32'(M_AXI_AWVALID), 32'd0);
    checkOutput("rstWvalid0", 32'(M_AXI_WVALID), 32'd0);
    checkOutput("rstArvalid0", 32'(M_AXI_ARVALID), 32'd0);
    checkOutput("rstBready0", 32'(M_AXI_BREADY), 32'd0);
    checkOutput("rstRready0", 32'(M_AXI_RREADY), 32'd0);
    checkOutput("rstBusy0", 32'(busy), 32'd0);
    checkOutput("rstDone0", 32'(done), 32'd0);
    checkOutput("rstError0", 32'(error), 32'd0);
    checkOutput("rstErrIdx0", 32'(err_index), 32'd0);
    checkOutput("rstAwaddr0", 32'(M_AXI_AWADDR), 32'd0);
    checkOutput("rstWdata0", M_AXI_WDATA, 32'd0);
    checkOutput("wstrb", 32'(M_AXI_WSTRB), 32'hF);
    checkOutput("prot", 32'({M_AXI_AWPROT, M_AXI_ARPROT}), 32'd0);
    ARESET = 1'b0;

    $display("[TB] zero-wait slave");
    setDelays(0, 0);
    applyStimulus({32'd4, 32'd3, 32'd2, 32'd1}, 0, 0, 1'b0, 1'b1);

    $display("[TB] AWREADY delayed by 3 cycles");
    setDelays(0, 0);
    awMin = 3; awMax = 3; awWait = 3;
    applyStimulus({32'hA5A5_0004, 32'h1234_0003, 32'h0F0F_0002, 32'hCAFE_0001}, 0, 0, 1'b0, 1'b0);

    $display("[TB] SLVERR on register 2");
    setDelays(0, 0);
    applyStimulus({32'h44, 32'h33, 32'h22, 32'h11}, 1, 2, 1'b0, 1'b0);

    $display("[TB] corrupted readback on register 3, then a clean run");
    applyStimulus({32'h8888, 32'h7777, 32'h6666, 32'h5555}, 2, 3, 1'b0, 1'b0);
    applyStimulus({32'h1111, 32'h2222, 32'h3333, 32'h4444}, 0, 0, 1'b0, 1'b0);

    $display("[TB] start pulsed mid-sequence");
    applyStimulus({32'hDDDD_0003, 32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000}, 0, 0, 1'b1, 1'b0);

    $display("[TB] reset while ARVALID awaits ARREADY");
    applyResetMidRead({32'h4, 32'h3, 32'h2, 32'h1});
    applyStimulus({32'h0BAD_0004, 32'h0BAD_0003, 32'h0BAD_0002, 32'h0BAD_0001}, 0, 0, 1'b0, 1'b0);

    $display("[TB] randomized sequences");
    for (int run = 0; run < 12; run++) begin
      for (int i = 0; i < NREG; i++) cfg[32*i +: 32] = $urandom;
      mode = $urandom_range(2, 0);
      fIdx = $urandom_range(NREG - 1, 0);
      if (cfg[32*fIdx +: 32] == 32'hDEAD0000) cfg[32*fIdx] = 1'b1;
      setDelays(0, $urandom_range(3, 0));
      applyStimulus(cfg, mode, fIdx, run[0], 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
